// File: rtl/alu_mul_pkg.sv
// Shared ALU package: common operand width, multiplier state encoding and
// iteration counter width. Also used by the iterative divider.
package alu_mul_pkg;

    // Common operand width shared by the multiplier and divider.
    localparam int OPR_LEN = 32;

    // Iteration counter width, clog2(OPR_LEN).
    localparam int MUL_CNT_W = 5;

    // Multiplier sequencing states.
    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

endpackage : alu_mul_pkg

// File: rtl/alu_abs.sv
// Conditional two's complement negation. With neg_i driven by an operand's
// sign bit it yields the magnitude; with neg_i driven by a result sign it
// performs the final negation. Only instantiated when ALU_MUL_SIGNED_EN is
// defined.
module alu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] mag_o
);

    // Negate when requested, otherwise pass the value through.
    always_comb begin
        mag_o = val_i;
        if (neg_i) begin
            mag_o = (~val_i) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_o = val_i;
        end
    end

endmodule : alu_abs

// File: rtl/alu_mul.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Fixed latency of WIDTH cycles from the accept edge to READY rising.
// Optional macro ALU_MUL_SIGNED_EN adds an is_signed input: operands are
// converted to magnitudes at accept and the product is negated on the
// completion edge when the operand signs differ.
module alu_mul
    import alu_mul_pkg::*;
#(
    parameter int WIDTH = OPR_LEN,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
`ifdef ALU_MUL_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic             READY,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mul_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    // Accumulator layout: {carry, hi, lo}.
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     opa_s;
    logic [WIDTH-1:0]     opb_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     step_s;
    logic [2*WIDTH-1:0]   result_s;

`ifdef ALU_MUL_SIGNED_EN
    logic                 neg_q, neg_d;
    logic                 neg_start_s;

    assign neg_start_s = is_signed & (src_A[WIDTH-1] ^ src_B[WIDTH-1]);

    alu_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (src_A),
        .neg_i (is_signed & src_A[WIDTH-1]),
        .mag_o (opa_s)
    );

    alu_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (src_B),
        .neg_i (is_signed & src_B[WIDTH-1]),
        .mag_o (opb_s)
    );

    // Final negation is folded into the completion edge.
    alu_abs #(.WIDTH(2*WIDTH)) u_neg_res (
        .val_i (step_s[2*WIDTH-1:0]),
        .neg_i (neg_q),
        .mag_o (result_s)
    );
`else
    assign opa_s    = src_A;
    assign opb_s    = src_B;
    assign result_s = step_s[2*WIDTH-1:0];
`endif

    // One shift-add iteration: conditional WIDTH+1-bit add into {carry,hi},
    // carry kept, then shift the whole accumulator right by one.
    always_comb begin
        sum_s = acc_q[2*WIDTH:WIDTH];
        if (acc_q[0]) begin
            sum_s = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        end else begin
            sum_s = acc_q[2*WIDTH:WIDTH];
        end
        step_s = {1'b0, sum_s, acc_q[WIDTH-1:1]};
    end

    // Next-state and datapath control for the IDLE/BUSY sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        ready_d = ready_q;
        done_d  = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d = MUL_BUSY;
                    mcand_d = opa_s;
                    acc_d   = {1'b0, {WIDTH{1'b0}}, opb_s};
                    cnt_d   = {CNT_W{1'b0}};
                    ready_d = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
                    neg_d   = neg_start_s;
`endif
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                acc_d = step_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = MUL_IDLE;
                    prod_d  = result_s;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = MUL_BUSY;
                end
            end
            default: begin
                state_d = MUL_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH+1){1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef ALU_MUL_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign product_hi = prod_q[2*WIDTH-1:WIDTH];
    assign product_lo = prod_q[WIDTH-1:0];
    assign READY      = ready_q;
    assign done       = done_q;

endmodule : alu_mul

// File: tb/tb_alu_mul.sv
// Self-checking bench for alu_mul: directed scenarios plus randomized
// operands checked against a plain-arithmetic reference product.
`timescale 1ns/1ps
module tb_alu_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_A, src_B;
    logic [31:0] product_hi, product_lo;
    logic        READY, done;
    logic        sgn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_A      (src_A),
        .src_B      (src_B),
`ifdef ALU_MUL_SIGNED_EN
        .is_signed  (sgn),
`endif
        .product_hi (product_hi),
        .product_lo (product_lo),
        .READY      (READY),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference product from integer arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Drive a request at a negedge; the next posedge accepts it.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        src_A = a;
        src_B = b;
        sgn   = s;
        start = 1'b1;
    endtask

    // Count negedges with READY low until READY returns; optionally inject
    // a start while busy, and check stale outputs hold during busy.
    task automatic wait_done(input bit hold, input int inject_at, input logic [63:0] stale,
                             output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (READY === 1'b1) break;
            busy_cycles++;
            if (busy_cycles == 5)
                check("stale_hold", {product_hi, product_lo}, stale);
            if (busy_cycles == inject_at) begin
                src_A = 32'd2; src_B = 32'd2; start = 1'b1;
            end else if (busy_cycles == inject_at + 1) begin
                start = 1'b0;
            end
        end
        if (READY !== 1'b1) check("timeout", {63'd0, READY}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag, input int inject_at);
        int n;
        logic [63:0] prev;
        prev = {product_hi, product_lo};
        launch(a, b, s);
        wait_done(1'b0, inject_at, prev, n);
        check({tag, "_lat"}, 64'(n), 64'd32);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_prod"}, {product_hi, product_lo}, ref_mul(a, b, s));
        @(negedge clk);
        check({tag, "_done_drop"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; src_A = 32'd0; src_B = 32'd0; sgn = 1'b0;
        #1;
        check("rst_ready", {63'd0, READY}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_prod", {product_hi, product_lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, "3x5", -1);
        check("3x5_lo", {32'd0, product_lo}, 64'd15);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "ffxff", -1);
        check("ffxff_val", {product_hi, product_lo}, 64'hFFFFFFFE_00000001);
        run_op(32'd7, 32'd9, 1'b0, "7x9_ign", 10);
        check("7x9_val", {product_hi, product_lo}, 64'd63);

        // Reset mid-operation.
        launch(32'h1234, 32'h10, 1'b0);
        repeat (15) @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mrst_ready", {63'd0, READY}, 64'd1);
        check("mrst_done", {63'd0, done}, 64'd0);
        check("mrst_prod", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("mrst_no_done", {63'd0, seen}, 64'd0);
        run_op(32'd4, 32'd4, 1'b0, "4x4", -1);

        // Start held high: back-to-back operations.
        launch(32'd2, 32'd3, 1'b0);
        wait_done(1'b1, -1, 64'd16, n);
        check("b2b1_lat", 64'(n), 64'd32);
        check("b2b1_prod", {product_hi, product_lo}, 64'd6);
        src_A = 32'd4; src_B = 32'd5;
        @(negedge clk);
        check("b2b2_accept", {63'd0, READY}, 64'd0);
        wait_done(1'b0, -1, 64'd6, n);
        check("b2b2_lat", 64'(n + 1), 64'd32);
        check("b2b2_prod", {product_hi, product_lo}, 64'd20);
        @(negedge clk);

        run_op(32'd0, 32'd0, 1'b0, "0x0", -1);

`ifdef ALU_MUL_SIGNED_EN
        run_op(32'hFFFFFFFD, 32'd7, 1'b1, "sgn_m3x7", -1);
        check("sgn_m3x7_val", {product_hi, product_lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(32'hFFFFFFFD, 32'd7, 1'b0, "uns_m3x7", -1);
        check("uns_m3x7_val", {product_hi, product_lo}, 64'h00000006_FFFFFFEB);
`endif

        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k == 3) ra = 32'd0;
            if (k == 4) rb = 32'h80000000;
            if (k == 5) ra = 32'h80000000;
`ifdef ALU_MUL_SIGNED_EN
            run_op(ra, rb, 1'($urandom_range(1, 0)), "rand", -1);
`else
            run_op(ra, rb, 1'b0, "rand", -1);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_mul
